// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div32_seq
//  Description : Sequential 32-bit restoring divider. One quotient bit per
//                cycle using a 33-bit trial subtraction, valid/ready operand
//                handshake, results held until the consumer acknowledges.
//                Optional macro DIV32_SIGNED_EN adds two's-complement division
//                through the in_signed port.
//  Revision    : 1.0 - initial release
// ============================================================================
module div32_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data0,
   input  logic [31:0] in_data1,
`ifdef DIV32_SIGNED_EN
   input  logic        in_signed,
`endif
   output logic        out_ready,
   output logic        out_valid,
   input  logic        in_ready,
   output logic [31:0] out_quotient,
   output logic [31:0] out_remainder,
   output logic        out_divzero,
   output logic        out_overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;

   state_t      r_state;
   logic [31:0] r_dvd;        // dividend shift register, fills with quotient bits
   logic [31:0] r_div;        // divisor magnitude
   logic [31:0] r_rem;        // partial remainder; always < divisor so 32 bits hold it
   logic [4:0]  r_cnt;
   logic        r_dz_pend;
   logic        r_ovf_pend;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_quo;
   logic [31:0] r_rmd;
   logic        r_valid;
   logic        r_dz;
   logic        r_ovf;

   logic        w_signed;
   logic        w_dvd_neg;
   logic        w_div_neg;
   logic        w_div_zero;
   logic        w_ovf;
   logic [31:0] w_dvd_mag;
   logic [31:0] w_div_mag;
   logic [32:0] w_trial;
   logic [31:0] w_rem_next;
   logic [31:0] w_quo_next;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

`ifdef DIV32_SIGNED_EN
   assign w_signed = in_signed;
`else
   assign w_signed = 1'b0;
`endif

   // Operand conditioning at accept: signs, magnitudes, special cases
   always_comb begin
      w_dvd_neg  = w_signed & in_data0[31];
      w_div_neg  = w_signed & in_data1[31];
      w_dvd_mag  = w_dvd_neg ? (~in_data0 + 32'd1) : in_data0;
      w_div_mag  = w_div_neg ? (~in_data1 + 32'd1) : in_data1;
      w_div_zero = (in_data1 == 32'd0);
      w_ovf      = w_signed && (in_data0 == c_INT_MIN) && (in_data1 == c_ALL_ONES);
   end

   // One restoring step plus the sign fix applied on the final iteration
   always_comb begin
      w_trial    = {r_rem, r_dvd[31]} - {1'b0, r_div};
      w_rem_next = w_trial[32] ? {r_rem[30:0], r_dvd[31]} : w_trial[31:0];
      w_quo_next = {r_dvd[30:0], ~w_trial[32]};
      w_q_fix    = r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
      w_r_fix    = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
   end

   // Control FSM with datapath and registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_dvd      <= 32'd0;
         r_div      <= 32'd0;
         r_rem      <= 32'd0;
         r_cnt      <= 5'd0;
         r_dz_pend  <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_quo      <= 32'd0;
         r_rmd      <= 32'd0;
         r_valid    <= 1'b0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_div      <= w_div_mag;
                  // zero divisor keeps the raw dividend for the remainder output
                  r_dvd      <= w_div_zero ? in_data0 : w_dvd_mag;
                  r_rem      <= 32'd0;
                  r_cnt      <= 5'd31;
                  r_dz_pend  <= w_div_zero;
                  r_ovf_pend <= w_ovf;
                  r_neg_q    <= w_dvd_neg ^ w_div_neg;
                  r_neg_r    <= w_dvd_neg;
                  // zero divisor takes a single pass cycle so its result
                  // appears on the edge after accept
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               if (r_dz_pend) begin
                  r_quo   <= c_ALL_ONES;
                  r_rmd   <= r_dvd;
                  r_dz    <= 1'b1;
                  r_ovf   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_rem <= w_rem_next;
                  r_dvd <= w_quo_next;
                  r_cnt <= r_cnt - 5'd1;
                  if (r_cnt == 5'd0) begin
                     r_quo   <= w_q_fix;
                     r_rmd   <= w_r_fix;
                     r_dz    <= 1'b0;
                     r_ovf   <= r_ovf_pend;
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (in_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_ready     = (r_state == S_IDLE);
   assign out_valid     = r_valid;
   assign out_quotient  = r_quo;
   assign out_remainder = r_rmd;
   assign out_divzero   = r_dz;
   assign out_overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div32_seq
//  Description : Scoreboard bench for div32_seq. Driver pushes hand-computed
//                results, a monitor pops and compares on each completion.
//                Signed vectors are built when DIV32_SIGNED_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data0;
   logic [31:0] in_data1;
   logic        in_signed;
   logic        out_ready;
   logic        out_valid;
   logic        in_ready;
   logic [31:0] out_quotient;
   logic [31:0] out_remainder;
   logic        out_divzero;
   logic        out_overflow;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   div32_seq u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data0      (in_data0),
      .in_data1      (in_data1),
`ifdef DIV32_SIGNED_EN
      .in_signed     (in_signed),
`endif
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .in_ready      (in_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_divzero   (out_divzero),
      .out_overflow  (out_overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare each completed result against the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid && in_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_completion", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("quotient",  {32'd0, out_quotient},  {32'd0, e.q});
            chk("remainder", {32'd0, out_remainder}, {32'd0, e.r});
            chk("divzero",   {63'd0, out_divzero},   {63'd0, e.dz});
            chk("overflow",  {63'd0, out_overflow},  {63'd0, e.ov});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!out_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!out_ready) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(posedge clk); #1;
      in_data0  = a;
      in_data1  = b;
      in_signed = s;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   // Returns number of edges after accept until out_valid is seen
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      if (!out_valid) chk("valid_timeout", 64'd1, 64'd0);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic dz, input logic ov);
      int lat;
      exp_t e;
      wait_idle();
      e.q = q; e.r = r; e.dz = dz; e.ov = ov;
      sb_q.push_back(e);
      accept(a, b, s);
      wait_valid(lat);
      chk("latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd32);
      @(posedge clk); #1;
      chk("idle_after", {62'd0, out_ready, out_valid}, 64'b10);
   endtask

   initial begin
      int   lat;
      bit   saw_valid;
      exp_t e;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data0  = 32'd0;
      in_data1  = 32'd0;
      in_signed = 1'b0;
      in_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ready",  {63'd0, out_ready}, 64'd1);
      chk("reset_valid",  {63'd0, out_valid}, 64'd0);
      chk("reset_quo",    {32'd0, out_quotient}, 64'd0);
      chk("reset_rem",    {32'd0, out_remainder}, 64'd0);
      chk("reset_flags",  {62'd0, out_divzero, out_overflow}, 64'd0);

      run_op(32'd100,        32'd7,          1'b0, 32'd14,         32'd2, 1'b0, 1'b0);
      run_op(32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0, 1'b0, 1'b0);
      run_op(32'h00000003,   32'hFFFFFFFF,   1'b0, 32'd0,          32'd3, 1'b0, 1'b0);
      run_op(32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5, 1'b1, 1'b0);
      run_op(32'd12345678,   32'd1000,       1'b0, 32'd12345,      32'd678, 1'b0, 1'b0);
      run_op(32'h80000000,   32'h10,         1'b0, 32'h08000000,   32'd0, 1'b0, 1'b0);
      run_op(32'd0,          32'd5,          1'b0, 32'd0,          32'd0, 1'b0, 1'b0);
      run_op(32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1, 1'b0, 1'b0);

      // Backpressure with an ignored operand pulse during CALC
      in_ready = 1'b0;
      wait_idle();
      e.q = 32'd8; e.r = 32'd2; e.dz = 1'b0; e.ov = 1'b0;
      sb_q.push_back(e);
      accept(32'd50, 32'd6, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      in_data0 = 32'd77; in_data1 = 32'd5; in_valid = 1'b1;
      chk("calc_not_ready", {63'd0, out_ready}, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_state", {62'd0, out_valid, out_ready}, 64'b10);
         chk("hold_data",  {out_quotient, out_remainder}, {32'd8, 32'd2});
      end
      in_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_after", {62'd0, out_ready, out_valid}, 64'b10);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      chk("no_extra_op", {63'd0, saw_valid}, 64'd0);

      // Reset at iteration 15 of 1000 / 3
      wait_idle();
      accept(32'd1000, 32'd3, 1'b0);
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("midrst_state", {62'd0, out_ready, out_valid}, 64'b10);
      chk("midrst_data",  {out_quotient, out_remainder}, 64'd0);
      run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 1'b0);

`ifdef DIV32_SIGNED_EN
      run_op(32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1);
      run_op(32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0);
      run_op(32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0);
      run_op(32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
